// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Purpose  : Bundles the SPI pins and the byte-level TX/RX handshake of the
//            spi_slave block.
// Ports    : slave modport  - i_* inputs, o_* outputs (the DUT view)
//            master modport - mirror view for whatever drives the block
// Revision : 1.0 - initial release
// ============================================================================
interface spi_slave_if;
  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;
  logic       o_TX_Pending;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       i_SPI_Clk;
  logic       i_SPI_CS_n;
  logic       i_SPI_MOSI;
  logic       o_SPI_MISO;
  logic       o_SPI_MISO_OE;

  modport slave (
    input  i_TX_DV, i_TX_Byte, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
    output o_TX_Pending, o_RX_DV, o_RX_Byte, o_SPI_MISO, o_SPI_MISO_OE
  );

  modport master (
    output i_TX_DV, i_TX_Byte, i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
    input  o_TX_Pending, o_RX_DV, o_RX_Byte, o_SPI_MISO, o_SPI_MISO_OE
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : SPI slave (modes 0..3, MSB first) that oversamples the SPI pins
//            with the system clock and exchanges one byte per 8 SPI clocks.
// Ports    : i_Clk  - system clock, all state on its rising edge
//            i_Rst  - asynchronous active-high reset
//            bus    - spi_slave_if.slave: TX load (i_TX_DV/i_TX_Byte,
//                     o_TX_Pending), RX output (o_RX_DV/o_RX_Byte) and the
//                     SPI pins (SCLK, CS_n, MOSI, MISO, MISO_OE)
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
  parameter int SPI_MODE = 0
) (
  input wire          i_Clk,
  input wire          i_Rst,
  spi_slave_if.slave  bus
);

  localparam logic c_CPOL = ((SPI_MODE & 2) != 0);
  localparam logic c_CPHA = ((SPI_MODE & 1) != 0);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Synchronizers: s1/s2 resolve metastability, s3 only serves edge detection
  logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic       cs_s1_q, cs_s2_q, cs_s3_q;
  logic       mosi_s1_q, mosi_s2_q;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_sr_q;
  logic [7:0] rx_byte_q;
  logic       rx_dv_q;
  logic [7:0] tx_sr_q;
  logic [7:0] tx_hold_q;
  logic       tx_pend_q;
  logic       miso_q;
  // Counts the first cycles after reset; the preset CS flops would otherwise
  // fake a falling edge when CS_n is already low at release.
  logic [1:0] flush_q;

  logic       w_lead, w_trail, w_sample, w_drive;
  logic       w_cs_fall, w_cs_rise;
  logic       w_last_bit, w_byte_start;
  logic [7:0] w_rx_next;
  logic [7:0] w_tx_load;

  assign w_lead    = (sclk_s2_q != c_CPOL) && (sclk_s3_q == c_CPOL);
  assign w_trail   = (sclk_s2_q == c_CPOL) && (sclk_s3_q != c_CPOL);
  assign w_sample  = c_CPHA ? w_trail : w_lead;
  assign w_drive   = c_CPHA ? w_lead  : w_trail;
  assign w_cs_fall = !cs_s2_q && cs_s3_q && (flush_q == 2'd3);
  assign w_cs_rise = cs_s2_q && !cs_s3_q;
  assign w_rx_next = {rx_sr_q[6:0], mosi_s2_q};

  assign w_last_bit   = (state_q == ST_ACTIVE) && !w_cs_rise && w_sample &&
                        (bit_cnt_q == 3'd7);
  assign w_byte_start = ((state_q == ST_IDLE) && w_cs_fall) || w_last_bit;
  // A load arriving in the byte-start cycle wins over the held byte
  assign w_tx_load    = bus.i_TX_DV ? bus.i_TX_Byte :
                        (tx_pend_q ? tx_hold_q : 8'h00);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sclk_s1_q <= c_CPOL;
      sclk_s2_q <= c_CPOL;
      sclk_s3_q <= c_CPOL;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= bus.i_SPI_Clk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      cs_s1_q   <= bus.i_SPI_CS_n;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      mosi_s1_q <= bus.i_SPI_MOSI;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      rx_sr_q   <= 8'h00;
      rx_byte_q <= 8'h00;
      rx_dv_q   <= 1'b0;
      tx_sr_q   <= 8'h00;
      tx_hold_q <= 8'h00;
      tx_pend_q <= 1'b0;
      miso_q    <= 1'b1;
      flush_q   <= 2'd0;
    end else begin
      rx_dv_q <= 1'b0;
      if (flush_q != 2'd3) begin
        flush_q <= flush_q + 2'd1;
      end

      case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= 3'd0;
          if (w_cs_fall) begin
            state_q <= ST_ACTIVE;
          end else begin
            miso_q <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            // Abort: partial byte is dropped, pending TX byte is kept
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            miso_q    <= 1'b1;
          end else begin
            if (w_sample) begin
              rx_sr_q   <= w_rx_next;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rx_byte_q <= w_rx_next;
                rx_dv_q   <= 1'b1;
              end
            end
            // CPHA=0 already shows the MSB at byte start, so the trailing
            // edge right after the byte boundary (count back at 0) must not
            // advance the shifter.
            if (w_drive && (c_CPHA || (bit_cnt_q != 3'd0))) begin
              miso_q  <= c_CPHA ? tx_sr_q[7] : tx_sr_q[6];
              tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (w_byte_start) begin
        tx_sr_q   <= w_tx_load;
        miso_q    <= w_tx_load[7];
        tx_pend_q <= 1'b0;
      end else if (bus.i_TX_DV) begin
        tx_hold_q <= bus.i_TX_Byte;
        tx_pend_q <= 1'b1;
      end
    end
  end

  assign bus.o_RX_DV       = rx_dv_q;
  assign bus.o_RX_Byte     = rx_byte_q;
  assign bus.o_TX_Pending  = tx_pend_q;
  assign bus.o_SPI_MISO    = miso_q;
  assign bus.o_SPI_MISO_OE = ~cs_s2_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Directed bench for spi_slave; one instance per SPI mode, each
//            driven by its own bit of the master-side signal vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;
  localparam int H = 8;  // SPI half-bit period in system clocks

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sclk, cs_n, mosi, tx_dv;
  logic [3:0] miso, oe, rx_dv, pend;
  logic [7:0] tx_byte [4];
  logic [7:0] rx_byte [4];
  int         dv_cnt  [4] = '{default: 0};
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] m_rx;
  int         base;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_slave_if u_if ();
    assign u_if.i_TX_DV    = tx_dv[g];
    assign u_if.i_TX_Byte  = tx_byte[g];
    assign u_if.i_SPI_Clk  = sclk[g];
    assign u_if.i_SPI_CS_n = cs_n[g];
    assign u_if.i_SPI_MOSI = mosi[g];
    assign miso[g]         = u_if.o_SPI_MISO;
    assign oe[g]           = u_if.o_SPI_MISO_OE;
    assign rx_dv[g]        = u_if.o_RX_DV;
    assign pend[g]         = u_if.o_TX_Pending;
    assign rx_byte[g]      = u_if.o_RX_Byte;
    spi_slave #(.SPI_MODE(g)) u_dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (u_if.slave)
    );
  end

  // Counts cycles with o_RX_DV high, so a stretched pulse shows up as extra
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_dv[i] === 1'b1) dv_cnt[i] <= dv_cnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input int m, input logic [7:0] b);
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    tick(1);
    tx_dv[m]   = 1'b0;
  endtask

  // Master side: clocks bits hi..lo of data, collecting MISO into m_rx
  task automatic shift_bits(input int m, input logic [7:0] data, input int hi, input int lo);
    logic cpol;
    cpol = (m >= 2);
    for (int i = hi; i >= lo; i--) begin
      if ((m % 2) == 0) begin
        mosi[m] = data[i];
        tick(H);
        m_rx    = {m_rx[6:0], miso[m]};
        sclk[m] = ~cpol;
        tick(H);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = data[i];
        tick(H);
        m_rx    = {m_rx[6:0], miso[m]};
        sclk[m] = cpol;
        tick(H);
      end
    end
  endtask

  initial begin
    sclk  = 4'b1100;
    cs_n  = 4'hF;
    mosi  = 4'h0;
    tx_dv = 4'h0;
    for (int i = 0; i < 4; i++) tx_byte[i] = 8'h00;
    m_rx  = 8'h00;
    rst   = 1'b1;
    tick(4);

    // Reset values, all modes
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst_rxdv_m%0d", m), rx_dv[m], 8'h00);
      chk($sformatf("rst_rxbyte_m%0d", m), rx_byte[m], 8'h00);
      chk($sformatf("rst_pend_m%0d", m), pend[m], 8'h00);
      chk($sformatf("rst_miso_m%0d", m), miso[m], 8'h01);
      chk($sformatf("rst_oe_m%0d", m), oe[m], 8'h00);
    end
    rst = 1'b0;
    tick(8);

    // Mode 3: preloaded 3C, master sends C1
    load_tx(3, 8'h3C);
    chk("m3_pend_set", pend[3], 8'h01);
    cs_n[3] = 1'b0;
    tick(H);
    chk("m3_pend_cleared_at_cs", pend[3], 8'h00);
    chk("m3_oe_active", oe[3], 8'h01);
    base = dv_cnt[3];
    m_rx = 8'h00;
    shift_bits(3, 8'hC1, 7, 0);
    tick(H);
    chk("m3_dv_count", 8'(dv_cnt[3] - base), 8'h01);
    chk("m3_rx_byte", rx_byte[3], 8'hC1);
    chk("m3_master_rx", m_rx, 8'h3C);
    cs_n[3] = 1'b1;
    tick(2 * H);

    // Mode 0: back-to-back BE, EF; slave returns A5 then 5A
    load_tx(0, 8'hA5);
    cs_n[0] = 1'b0;
    tick(H);
    base = dv_cnt[0];
    m_rx = 8'h00;
    shift_bits(0, 8'hBE, 7, 4);
    load_tx(0, 8'h5A);
    chk("m0_pend_midbyte", pend[0], 8'h01);
    shift_bits(0, 8'hBE, 3, 0);
    chk("m0_dv_count_b1", 8'(dv_cnt[0] - base), 8'h01);
    chk("m0_rx_b1", rx_byte[0], 8'hBE);
    chk("m0_master_rx_b1", m_rx, 8'hA5);
    chk("m0_pend_after_b1", pend[0], 8'h00);
    m_rx = 8'h00;
    shift_bits(0, 8'hEF, 7, 0);
    tick(H);
    chk("m0_dv_count_b2", 8'(dv_cnt[0] - base), 8'h02);
    chk("m0_rx_b2", rx_byte[0], 8'hEF);
    chk("m0_master_rx_b2", m_rx, 8'h5A);
    cs_n[0] = 1'b1;
    tick(2 * H);

    // Mode 1: nothing loaded, master sends 81
    cs_n[1] = 1'b0;
    tick(H);
    base = dv_cnt[1];
    m_rx = 8'hFF;
    shift_bits(1, 8'h81, 7, 0);
    tick(H);
    chk("m1_master_rx_zero", m_rx, 8'h00);
    chk("m1_rx_byte", rx_byte[1], 8'h81);
    chk("m1_dv_count", 8'(dv_cnt[1] - base), 8'h01);
    cs_n[1] = 1'b1;
    tick(2 * H);

    // Mode 2: aborted 5-bit byte, then full 6D
    cs_n[2] = 1'b0;
    tick(H);
    base = dv_cnt[2];
    shift_bits(2, 8'hFF, 7, 3);
    load_tx(2, 8'h99);
    cs_n[2] = 1'b1;
    tick(2 * H);
    chk("m2_no_dv_partial", 8'(dv_cnt[2] - base), 8'h00);
    chk("m2_pend_kept", pend[2], 8'h01);
    cs_n[2] = 1'b0;
    tick(H);
    m_rx = 8'h00;
    shift_bits(2, 8'h6D, 7, 0);
    tick(H);
    chk("m2_dv_count", 8'(dv_cnt[2] - base), 8'h01);
    chk("m2_rx_byte", rx_byte[2], 8'h6D);
    chk("m2_master_rx", m_rx, 8'h99);
    chk("m2_pend_consumed", pend[2], 8'h00);
    cs_n[2] = 1'b1;
    tick(2 * H);

    // Mode 0: reset after 3 bits of F0, then a clean 0F
    load_tx(0, 8'h77);
    cs_n[0] = 1'b0;
    tick(H);
    base = dv_cnt[0];
    shift_bits(0, 8'hF0, 7, 5);
    rst = 1'b1;
    tick(2);
    chk("rst_mid_rxdv", rx_dv[0], 8'h00);
    chk("rst_mid_rxbyte", rx_byte[0], 8'h00);
    chk("rst_mid_pend", pend[0], 8'h00);
    chk("rst_mid_miso", miso[0], 8'h01);
    chk("rst_mid_oe", oe[0], 8'h00);
    rst = 1'b0;
    shift_bits(0, 8'hF0, 4, 0);
    tick(H);
    chk("rst_mid_no_dv", 8'(dv_cnt[0] - base), 8'h00);
    cs_n[0] = 1'b1;
    tick(2 * H);
    cs_n[0] = 1'b0;
    tick(H);
    m_rx = 8'hFF;
    shift_bits(0, 8'h0F, 7, 0);
    tick(H);
    chk("post_rst_rx_byte", rx_byte[0], 8'h0F);
    chk("post_rst_dv_count", 8'(dv_cnt[0] - base), 8'h01);
    chk("post_rst_master_rx", m_rx, 8'h00);
    cs_n[0] = 1'b1;
    tick(2 * H);

    // Mode 0: SCLK toggling with CS_n high must be ignored
    base = dv_cnt[0];
    for (int i = 0; i < 8; i++) begin
      mosi[0] = i[0];
      sclk[0] = 1'b1;
      tick(H);
      if (i == 3) begin
        chk("cs_hi_oe", oe[0], 8'h00);
        chk("cs_hi_miso", miso[0], 8'h01);
      end
      sclk[0] = 1'b0;
      tick(H);
    end
    chk("cs_hi_no_dv", 8'(dv_cnt[0] - base), 8'h00);
    chk("cs_hi_bitcnt", 8'(g_mode[0].u_dut.bit_cnt_q), 8'h00);
    chk("cs_hi_rx_unchanged", rx_byte[0], 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
